game_led_pwm_driver: RTL



---
 rtl/game_led_pwm_driver_pkg.sv | 16 +
 rtl/game_led_pwm_driver_tick.sv | 46 ++++
 rtl/game_led_pwm_driver.sv | 128 ++++++++++++
 3 files changed

// File: rtl/game_led_pwm_driver_pkg.sv
// Shared constants for the green-LED PWM driver: register addresses,
// CTRL bit positions and the last PWM counter value of a period.
package game_led_pwm_driver_pkg;

  localparam logic [1:0] ADDR_CTRL      = 2'd0;
  localparam logic [1:0] ADDR_DUTY      = 2'd1;
  localparam logic [1:0] ADDR_BLINK_DIV = 2'd2;
  localparam logic [1:0] ADDR_STATUS    = 2'd3;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_BLINK_BIT  = 1;

  // pwm_cnt runs 0..PWM_MAX, i.e. 255 ticks per PWM period.
  localparam logic [7:0] PWM_MAX = 8'd254;

endpackage

// File: rtl/game_led_pwm_driver_tick.sv
// Prescaler and PWM counter for the LED driver.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   tick         : one clk wide, every PRESCALE clks
//   pstart       : last tick of a PWM period (pwm_cnt == PWM_MAX on a tick)
//   pwm_cnt      : current PWM step, 0..PWM_MAX
module game_led_pwm_tick
  import game_led_pwm_driver_pkg::*;
#(
  parameter int PRESCALE = 196
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       tick,
  output logic       pstart,
  output logic [7:0] pwm_cnt
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;

  always_comb begin
    tick        = (presc_cnt_q == PRESC_LAST);
    pstart      = tick && (pwm_cnt_q == PWM_MAX);
    pwm_cnt     = pwm_cnt_q;
    presc_cnt_d = tick ? '0 : presc_cnt_q + PW'(1);
    pwm_cnt_d   = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = (pwm_cnt_q == PWM_MAX) ? 8'd0 : pwm_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= 8'd0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

endmodule

// File: rtl/game_led_pwm_driver.sv
// Green-LED PWM driver: takes the PIO out_port pattern and drives LEDG with
// global PWM dimming and optional blinking. LED pattern and duty are only
// latched at PWM period boundaries so register writes never glitch the LEDs.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata     : zero-wait Avalon-MM slave write side
//   readdata               : combinational read data, selected by address only
//   led_in                 : LED pattern from the PIO
//   led_out                : registered drive to the LEDG pins
module game_led_pwm_driver
  import game_led_pwm_driver_pkg::*;
#(
  parameter int          PRESCALE  = 196,
  parameter logic [15:0] BLINK_RST = 16'h0100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [7:0]  led_in,
  output logic [7:0]  led_out
);

  logic        pwm_tick_unused;
  logic        pstart;
  logic [7:0]  pwm_cnt;

  game_led_pwm_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (pwm_tick_unused),
    .pstart  (pstart),
    .pwm_cnt (pwm_cnt)
  );

  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] blink_div_q, blink_div_d;
  logic [7:0]  led_act_q, led_act_d;
  logic [7:0]  duty_act_q, duty_act_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [7:0]  led_out_q, led_out_d;

  logic        wr_en;
  logic [15:0] blink_lim;
  logic        pwm_on;
  logic        blink_vis;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:16];

  always_comb begin
    wr_en = chipselect && !write_n;

    ctrl_d      = ctrl_q;
    duty_d      = duty_q;
    blink_div_d = blink_div_q;
    if (wr_en) begin
      case (address)
        ADDR_CTRL:      ctrl_d      = writedata[1:0];
        ADDR_DUTY:      duty_d      = writedata[7:0];
        ADDR_BLINK_DIV: blink_div_d = writedata[15:0];
        default:        ;
      endcase
    end

    // BLINK_DIV of 0 acts as 1. The >= compare also catches a divider
    // written below the running count: it toggles on the next boundary.
    blink_lim     = (blink_div_q == 16'd0) ? 16'd0 : blink_div_q - 16'd1;
    led_act_d     = led_act_q;
    duty_act_d    = duty_act_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (pstart) begin
      // duty_q here is the pre-write value if a DUTY write lands on pstart.
      led_act_d  = led_in;
      duty_act_d = duty_q;
      if (blink_cnt_q >= blink_lim) begin
        blink_cnt_d   = 16'd0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    // pwm_cnt never exceeds 254, so duty 255 is on for the whole period.
    pwm_on    = (pwm_cnt < duty_act_q);
    blink_vis = !ctrl_q[CTRL_BLINK_BIT] || blink_phase_q;
    led_out_d = (ctrl_q[CTRL_ENABLE_BIT] && pwm_on && blink_vis) ? led_act_q : 8'h00;

    case (address)
      ADDR_CTRL:      readdata = {30'd0, ctrl_q};
      ADDR_DUTY:      readdata = {24'd0, duty_q};
      ADDR_BLINK_DIV: readdata = {16'd0, blink_div_q};
      default:        readdata = {8'd0, duty_act_q, 7'd0, blink_phase_q, led_act_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q        <= 2'd0;
      duty_q        <= 8'hFF;
      blink_div_q   <= BLINK_RST;
      led_act_q     <= 8'h00;
      duty_act_q    <= 8'hFF;
      blink_cnt_q   <= 16'd0;
      blink_phase_q <= 1'b1;
      led_out_q     <= 8'h00;
    end else begin
      ctrl_q        <= ctrl_d;
      duty_q        <= duty_d;
      blink_div_q   <= blink_div_d;
      led_act_q     <= led_act_d;
      duty_act_q    <= duty_act_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_out_q     <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule
